// File: rtl/jk_seq_driver.sv
// jk_seq_driver: queues target patterns and drives a JK flip-flop bank to each one.
// Optional build macro JK_TOGGLE_OPT_EN: changing bits toggle (J=K=1), holding bits J=K=0.
module jk_seq_driver #(
  parameter int WIDTH   = 4,
  parameter int DEPTH   = 8,
  parameter int DC_FILL = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] tgt_data,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  input  logic             run,
  input  logic             clr_err,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] err_bits,
  output logic [7:0]       step_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic DC_BIT = (DC_FILL != 0);

  typedef enum logic [1:0] {IDLE, APPLY, CHECK} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic [WIDTH-1:0] j_q, j_d, k_q, k_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] err_bits_q, err_bits_d;
  logic [7:0]       step_cnt_q, step_cnt_d;

  logic             full, empty, push, pop;
  logic [WIDTH-1:0] head, exc_j, exc_k, diff;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign push  = tgt_valid && !full;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    exc_j = '0;
    exc_k = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
`ifdef JK_TOGGLE_OPT_EN
      exc_j[i] = q_fb[i] ^ head[i];
      exc_k[i] = q_fb[i] ^ head[i];
`else
      if (!q_fb[i]) begin
        exc_j[i] = head[i];
        exc_k[i] = DC_BIT;
      end else begin
        exc_j[i] = DC_BIT;
        exc_k[i] = !head[i];
      end
`endif
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // A clear coinciding with a mismatching exit keeps only the new diff.
  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    tgt_d      = tgt_q;
    j_d        = '0;
    k_d        = '0;
    done_d     = 1'b0;
    step_cnt_d = step_cnt_q;
    err_d      = clr_err ? 1'b0 : err_q;
    err_bits_d = clr_err ? '0 : err_bits_q;
    diff       = q_fb ^ tgt_q;
    case (state_q)
      IDLE: begin
        if (run && !empty) begin
          pop     = 1'b1;
          tgt_d   = head;
          j_d     = exc_j;
          k_d     = exc_k;
          state_d = APPLY;
        end
      end
      APPLY: state_d = CHECK;
      CHECK: begin
        state_d    = IDLE;
        done_d     = 1'b1;
        step_cnt_d = step_cnt_q + 8'd1;
        if (diff != '0) begin
          err_d      = 1'b1;
          err_bits_d = err_bits_d | diff;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= tgt_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tgt_q      <= '0;
      j_q        <= '0;
      k_q        <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_bits_q <= '0;
      step_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      tgt_q      <= tgt_d;
      j_q        <= j_d;
      k_q        <= k_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_bits_q <= err_bits_d;
      step_cnt_q <= step_cnt_d;
    end
  end

  assign tgt_ready = !full;
  assign busy      = (state_q != IDLE);
  assign j         = j_q;
  assign k         = k_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_bits  = err_bits_q;
  assign step_cnt  = step_cnt_q;

endmodule

// File: tb/tb_jk_seq_driver.sv
// Bench for jk_seq_driver with a behavioural JK bank on q_fb.
module tb_jk_seq_driver;

`ifdef JK_TOGGLE_OPT_EN
  localparam bit TOG = 1'b1;
`else
  localparam bit TOG = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset, tgt_valid, run, clr_err;
  logic [3:0] tgt_data, q_fb, force_val;
  logic [3:0] bank_q = '0;
  logic       force_en;

  logic       tgt_ready, busy, done, err;
  logic [3:0] j, k, err_bits;
  logic [7:0] step_cnt;

  logic       tgt_ready_1, busy_1, done_1, err_1;
  logic [3:0] j_1, k_1, err_bits_1;
  logic [7:0] step_cnt_1;

  int checks   = 0;
  int failures = 0;
  int exp_cnt  = 0;

  jk_seq_driver #(.WIDTH(4), .DEPTH(8), .DC_FILL(0)) dut (
    .clock(clock), .reset(reset), .tgt_data(tgt_data), .tgt_valid(tgt_valid),
    .tgt_ready(tgt_ready), .run(run), .clr_err(clr_err), .q_fb(q_fb),
    .j(j), .k(k), .busy(busy), .done(done), .err(err), .err_bits(err_bits),
    .step_cnt(step_cnt)
  );

  jk_seq_driver #(.WIDTH(4), .DEPTH(8), .DC_FILL(1)) dut_dc1 (
    .clock(clock), .reset(reset), .tgt_data(tgt_data), .tgt_valid(tgt_valid),
    .tgt_ready(tgt_ready_1), .run(run), .clr_err(clr_err), .q_fb(q_fb),
    .j(j_1), .k(k_1), .busy(busy_1), .done(done_1), .err(err_1), .err_bits(err_bits_1),
    .step_cnt(step_cnt_1)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    for (int i = 0; i < 4; i++) begin
      case ({j[i], k[i]})
        2'b10:   bank_q[i] <= 1'b1;
        2'b01:   bank_q[i] <= 1'b0;
        2'b11:   bank_q[i] <= ~bank_q[i];
        default: bank_q[i] <= bank_q[i];
      endcase
    end
  end

  assign q_fb = force_en ? force_val : bank_q;

  typedef struct {
    logic [3:0] tgt;
    logic [3:0] j0, k0;
    logic [3:0] j1, k1;
    logic [3:0] jt;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Starts at a negedge with the FSM idle, FIFO empty and run=1.
  task automatic do_step(input logic [3:0] t, input logic chk_jk,
                         input logic [3:0] ej0, input logic [3:0] ek0,
                         input logic [3:0] ej1, input logic [3:0] ek1,
                         input logic frc, input logic [3:0] fv, input logic clr,
                         input logic exp_err, input logic [3:0] exp_bits);
    tgt_data  = t;
    tgt_valid = 1'b1;
    @(negedge clock);
    tgt_valid = 1'b0;
    @(negedge clock);
    chk("apply_busy", busy, 1);
    chk("apply_done", done, 0);
    if (chk_jk) begin
      chk("apply_j", j, ej0);
      chk("apply_k", k, ek0);
      chk("apply_j_dc1", j_1, ej1);
      chk("apply_k_dc1", k_1, ek1);
    end
    @(negedge clock);
    chk("check_j", j, 0);
    chk("check_k", k, 0);
    chk("check_busy", busy, 1);
    chk("check_done", done, 0);
    chk("bank_reach", bank_q, t);
    force_en  = frc;
    force_val = fv;
    clr_err   = clr;
    @(negedge clock);
    force_en = 1'b0;
    clr_err  = 1'b0;
    exp_cnt++;
    chk("exit_done", done, 1);
    chk("exit_step_cnt", step_cnt, exp_cnt);
    chk("exit_err", err, exp_err);
    chk("exit_err_bits", err_bits, exp_bits);
    chk("exit_busy", busy, 0);
    chk("exit_j", j, 0);
    chk("exit_k", k, 0);
    @(negedge clock);
    chk("done_one_cycle", done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{4'b1010, 4'b1010, 4'b0000, 4'b1010, 4'b1111, 4'b1010};
    tbl[1] = '{4'b0110, 4'b0100, 4'b1000, 4'b1110, 4'b1101, 4'b1100};
    tbl[2] = '{4'b1111, 4'b1001, 4'b0000, 4'b1111, 4'b1001, 4'b1001};
    tbl[3] = '{4'b0000, 4'b0000, 4'b1111, 4'b1111, 4'b1111, 4'b1111};
    tbl[4] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0000};
    tbl[5] = '{4'b0101, 4'b0101, 4'b0000, 4'b0101, 4'b1111, 4'b0101};
    tbl[6] = '{4'b1100, 4'b1000, 4'b0001, 4'b1101, 4'b1011, 4'b1001};

    reset = 1'b1; run = 1'b0; tgt_valid = 1'b0; tgt_data = '0;
    clr_err = 1'b0; force_en = 1'b0; force_val = '0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_j", j, 0);
    chk("rst_k", k, 0);
    chk("rst_ready", tgt_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_err_bits", err_bits, 0);
    chk("rst_step_cnt", step_cnt, 0);

    run = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (TOG)
        do_step(tbl[i].tgt, 1'b1, tbl[i].jt, tbl[i].jt, tbl[i].jt, tbl[i].jt,
                1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000);
      else
        do_step(tbl[i].tgt, 1'b1, tbl[i].j0, tbl[i].k0, tbl[i].j1, tbl[i].k1,
                1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000);
    end

    do_step(4'b0110, 1'b0, '0, '0, '0, '0, 1'b1, 4'b0111, 1'b0, 1'b1, 4'b0001);
    do_step(4'b0110, 1'b0, '0, '0, '0, '0, 1'b0, 4'b0000, 1'b0, 1'b1, 4'b0001);
    do_step(4'b0110, 1'b0, '0, '0, '0, '0, 1'b1, 4'b0100, 1'b1, 1'b1, 4'b0010);
    clr_err = 1'b1;
    @(negedge clock);
    clr_err = 1'b0;
    chk("clr_err", err, 0);
    chk("clr_err_bits", err_bits, 0);

    run = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tgt_data  = 4'(i);
      tgt_valid = 1'b1;
      chk("fill_ready", tgt_ready, 1);
      @(negedge clock);
    end
    tgt_data = 4'd9;
    chk("full_ready", tgt_ready, 0);
    @(negedge clock);
    chk("full_hold_ready", tgt_ready, 0);
    chk("run0_busy", busy, 0);
    run = 1'b1;
    begin
      int seen = 0;
      int last = 0;
      int acc_cyc = -1;
      bit armed = 1'b0;
      for (int cyc = 0; cyc < 60 && seen < 9; cyc++) begin
        @(negedge clock);
        if (armed) begin
          tgt_valid = 1'b0;
          armed = 1'b0;
        end else if (tgt_valid && tgt_ready) begin
          armed = 1'b1;
          acc_cyc = cyc;
        end
        if (done) begin
          seen++;
          chk("fifo_order", bank_q, seen);
          chk("fifo_err", err, 0);
          if (seen > 1) chk("done_spacing", cyc - last, 3);
          last = cyc;
        end
      end
      chk("ninth_accept_cycle", acc_cyc, 0);
      chk("fifo_done_count", seen, 9);
      exp_cnt += 9;
      chk("fifo_step_cnt", step_cnt, exp_cnt);
    end

    run = 1'b0;
    tgt_data = 4'b0011; tgt_valid = 1'b1;
    @(negedge clock);
    tgt_data = 4'b1100;
    @(negedge clock);
    tgt_valid = 1'b0;
    run = 1'b1;
    @(negedge clock);
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_j", j, TOG ? 4'b1010 : 4'b0010);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("apply_rst_j", j, 0);
    chk("apply_rst_k", k, 0);
    chk("apply_rst_busy", busy, 0);
    chk("apply_rst_step_cnt", step_cnt, 0);
    chk("apply_rst_ready", tgt_ready, 1);
    chk("apply_rst_done", done, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("post_rst_empty_busy", busy, 0);
      chk("post_rst_no_done", done, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
